sprite_bounce_mover: RTL and testbench
======================================

Name: sprite_bounce_mover

Overview:
- Frame-rate position generator for a rectangular sprite bouncing inside a configurable VGA active area.
- Parametrised successor of the fixed-size, unit-step bouncing mover.
- Adds programmable per-axis speed, pause, overshoot clamping, and wall/corner hit pulses.
- Sits between the VGA timing generator (supplies the frame tick) and the sprite renderer (consumes hpos/vpos as the sprite's top-left corner).

Parameters:
SCREEN_W, 640, active area width in pixels
SCREEN_H, 480, active area height in pixels
SPR_W, 135, sprite width in pixels
SPR_H, 135, sprite height in pixels
POS_W, 12, width of position outputs
STEP_W, 8, width of per-axis step inputs

Ports:
clk_25MHz  input  1  pixel clock; the block's only clock
rst_n  input  1  asynchronous active-low reset
VS_negedge  input  1  one-cycle frame tick; all updates happen only on cycles where it is high
loc_rst  input  1  recentre request, sampled on the frame tick
en  input  1  motion enable, sampled on the frame tick; 0 = freeze
step_x  input  STEP_W  pixels moved per frame on x; 0 = x stationary
step_y  input  STEP_W  pixels moved per frame on y; 0 = y stationary
hpos  output  POS_W  sprite left x, range 0..XMAX
vpos  output  POS_W  sprite top y, range 0..YMAX
dir  output  2  bit1 = x increasing, bit0 = y increasing
hit_x  output  1  one-cycle pulse: left or right wall reached this frame
hit_y  output  1  one-cycle pulse: top or bottom wall reached this frame
corner_hit  output  1  one-cycle pulse: hit_x and hit_y in the same frame

Behaviour:
- Constants:
  - XMAX = SCREEN_W-SPR_W and YMAX = SCREEN_H-SPR_H (505 and 345 at defaults).
  - XC = XMAX/2 and YC = YMAX/2, using floor division (252 and 172 at defaults).
- Elaboration-time checks: SPR_W < SCREEN_W; SPR_H < SCREEN_H; XMAX < 2^POS_W.
- Reset (rst_n low, asynchronous): hpos=0, vpos=0, dir=2'b11, hit_x=0, hit_y=0, corner_hit=0.
- All outputs are registered. Updates land on the clock edge at which VS_negedge=1 is sampled, so they are visible the following cycle. Latency is 1 cycle.
- Pulses: hit_x, hit_y and corner_hit go high only in the cycle after a tick. They are 0 on every other cycle.
- Priority on a tick: loc_rst, then en=0, then move.
- loc_rst=1 on a tick, regardless of en:
  - hpos=XC, vpos=YC.
  - dir <= dir+1, modulo 4: launch direction rotates 11 -> 00 -> 01 -> 10 -> 11.
  - No hit pulses.
- en=0 on a tick (no loc_rst): all state holds; no pulses.
- Move, per axis, shown for x (y is identical with vpos, step_y, YMAX, dir[0], hit_y):
  - Compute in POS_W+1 bits.
  - dir[1]=1: nx = hpos+step_x.
    - If nx >= XMAX: hpos=XMAX, dir[1]=0, hit_x=1.
    - Else hpos=nx.
  - dir[1]=0: nx = hpos-step_x, signed.
    - If nx <= 0: hpos=0, dir[1]=1, hit_x=1.
    - Else hpos=nx.
  - Landing exactly on a bound counts as a hit and flips direction.
  - Overshoot is clamped to the bound; no reflection of the excess.
  - step=0: axis holds and never hits, even when sitting on a bound.
- corner_hit = hit_x AND hit_y, registered together with them.
- Invariant: 0<=hpos<=XMAX and 0<=vpos<=YMAX at all times after reset.
- step_x and step_y are sampled only on ticks; changes between ticks have no effect.
- Reset asserted mid-frame or mid-move: immediate return to reset values; the next tick after release moves from (0,0) with dir=11.
- Back-to-back ticks on consecutive cycles are each processed.

Test Plan:
- Reset, step=1/1, en=1, 3 ticks -> (1,1), (2,2), (3,3); dir=11; no pulses.
- Reset, step_x=4, step_y=1, 127 ticks:
  - After tick 126: hpos=504.
  - Tick 127: hpos=505 (clamped from 508), vpos=127, dir=01, hit_x pulse for 1 cycle, hit_y=0.
- Reset, then loc_rst tick -> (252,172), dir=00. Then step=5/5:
  - After 34 ticks: (82,2).
  - Tick 35: (77,0), dir=01, hit_y=1, hit_x=0.
- Reset, loc_rst tick (dir=00), step_x=252, step_y=172, 1 tick -> (0,0), dir=11, hit_x=hit_y=corner_hit=1 for exactly 1 cycle.
- en=0 for 10 ticks -> position and dir unchanged, no pulses. Then loc_rst with en=0 -> (252,172) and dir advances by 1.
- Mid-run rst_n low for 3 cycles off a clock edge -> outputs are 0 and dir=11 immediately. The first tick after release gives (step_x, step_y).

Source files
------------

// File: rtl/sprite_bounce_mover_if.sv
// sprite_bounce_mover_if: frame-tick controls in, sprite position and wall-hit pulses out.
interface sprite_bounce_mover_if #(
    parameter int POS_W  = 12,
    parameter int STEP_W = 8
);
    logic              VS_negedge;
    logic              loc_rst;
    logic              en;
    logic [STEP_W-1:0] step_x;
    logic [STEP_W-1:0] step_y;
    logic [POS_W-1:0]  hpos;
    logic [POS_W-1:0]  vpos;
    logic [1:0]        dir;
    logic              hit_x;
    logic              hit_y;
    logic              corner_hit;

    modport master (
        output VS_negedge, loc_rst, en, step_x, step_y,
        input  hpos, vpos, dir, hit_x, hit_y, corner_hit
    );

    modport slave (
        input  VS_negedge, loc_rst, en, step_x, step_y,
        output hpos, vpos, dir, hit_x, hit_y, corner_hit
    );
endinterface

// File: rtl/sprite_bounce_mover.sv
// sprite_bounce_mover: per-frame top-left position of a sprite bouncing inside the active area,
// with programmable per-axis speed, freeze, recentre and clamped wall/corner hit pulses.
module sprite_bounce_mover #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int SPR_W    = 135,
    parameter int SPR_H    = 135,
    parameter int POS_W    = 12,
    parameter int STEP_W   = 8
) (
    input logic                  clk_25MHz,
    input logic                  rst_n,
    sprite_bounce_mover_if.slave bus
);
    localparam int XMAX_I = SCREEN_W - SPR_W;
    localparam int YMAX_I = SCREEN_H - SPR_H;
    localparam logic [POS_W-1:0] XMAX = POS_W'(XMAX_I);
    localparam logic [POS_W-1:0] YMAX = POS_W'(YMAX_I);
    localparam logic [POS_W-1:0] XC   = POS_W'(XMAX_I / 2);
    localparam logic [POS_W-1:0] YC   = POS_W'(YMAX_I / 2);

    if (SPR_W >= SCREEN_W) begin : g_bad_w
        $error("sprite_bounce_mover: SPR_W must be smaller than SCREEN_W");
    end
    if (SPR_H >= SCREEN_H) begin : g_bad_h
        $error("sprite_bounce_mover: SPR_H must be smaller than SCREEN_H");
    end
    if (XMAX_I >= (1 << POS_W) || YMAX_I >= (1 << POS_W)) begin : g_bad_pos
        $error("sprite_bounce_mover: POS_W too narrow for the travel range");
    end

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic             dir;
        logic             hit;
    } axis_t;

    // One axis step; the extra top bit catches both overshoot past the far wall and
    // underflow below zero, and either is clamped onto the wall rather than reflected.
    function automatic axis_t move_axis(
        input logic [POS_W-1:0]  p,
        input logic [STEP_W-1:0] s,
        input logic              d,
        input logic [POS_W-1:0]  lim
    );
        logic [POS_W:0] n;
        move_axis = '{pos: p, dir: d, hit: 1'b0};
        if (s != '0) begin
            if (d) begin
                n = {1'b0, p} + (POS_W+1)'(s);
                move_axis = (n >= {1'b0, lim}) ? '{pos: lim, dir: 1'b0, hit: 1'b1}
                                               : '{pos: n[POS_W-1:0], dir: 1'b1, hit: 1'b0};
            end else begin
                n = {1'b0, p} - (POS_W+1)'(s);
                move_axis = (n[POS_W] || n == '0) ? '{pos: '0, dir: 1'b1, hit: 1'b1}
                                                  : '{pos: n[POS_W-1:0], dir: 1'b0, hit: 1'b0};
            end
        end
    endfunction

    logic [POS_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
    logic [1:0]       dir_q, dir_d;
    logic             hit_x_q, hit_x_d, hit_y_q, hit_y_d, corner_q, corner_d;
    axis_t            ax, ay;

    always_comb begin
        ax       = move_axis(hpos_q, bus.step_x, dir_q[1], XMAX);
        ay       = move_axis(vpos_q, bus.step_y, dir_q[0], YMAX);
        hpos_d   = hpos_q;
        vpos_d   = vpos_q;
        dir_d    = dir_q;
        hit_x_d  = 1'b0;
        hit_y_d  = 1'b0;
        if (bus.VS_negedge) begin
            if (bus.loc_rst) begin
                hpos_d = XC;
                vpos_d = YC;
                dir_d  = dir_q + 2'd1;
            end else if (bus.en) begin
                hpos_d  = ax.pos;
                vpos_d  = ay.pos;
                dir_d   = {ax.dir, ay.dir};
                hit_x_d = ax.hit;
                hit_y_d = ay.hit;
            end
        end
        corner_d = hit_x_d & hit_y_d;
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q   <= '0;
            vpos_q   <= '0;
            dir_q    <= 2'b11;
            hit_x_q  <= 1'b0;
            hit_y_q  <= 1'b0;
            corner_q <= 1'b0;
        end else begin
            hpos_q   <= hpos_d;
            vpos_q   <= vpos_d;
            dir_q    <= dir_d;
            hit_x_q  <= hit_x_d;
            hit_y_q  <= hit_y_d;
            corner_q <= corner_d;
        end
    end

    assign bus.hpos       = hpos_q;
    assign bus.vpos       = vpos_q;
    assign bus.dir        = dir_q;
    assign bus.hit_x      = hit_x_q;
    assign bus.hit_y      = hit_y_q;
    assign bus.corner_hit = corner_q;
endmodule

// File: tb/tb_sprite_bounce_mover.sv
// tb_sprite_bounce_mover: directed vectors with hand-computed positions, directions and pulses.
module tb_sprite_bounce_mover;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    sprite_bounce_mover_if bus ();

    sprite_bounce_mover dut (
        .clk_25MHz (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input int h, input int v, input int d,
                               input int hx, input int hy, input int hc);
        check({tag, ".hpos"}, int'(bus.hpos), h);
        check({tag, ".vpos"}, int'(bus.vpos), v);
        check({tag, ".dir"}, int'(bus.dir), d);
        check({tag, ".hit_x"}, int'(bus.hit_x), hx);
        check({tag, ".hit_y"}, int'(bus.hit_y), hy);
        check({tag, ".corner"}, int'(bus.corner_hit), hc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Tick asserted for one cycle; returns at the following falling edge, inside the pulse cycle.
    task automatic tick();
        @(negedge clk);
        bus.VS_negedge = 1'b1;
        @(negedge clk);
        bus.VS_negedge = 1'b0;
    endtask

    task automatic set_step(input int sx, input int sy);
        bus.step_x = 8'(sx);
        bus.step_y = 8'(sy);
    endtask

    initial begin
        bus.VS_negedge = 1'b0;
        bus.loc_rst    = 1'b0;
        bus.en         = 1'b1;
        set_step(1, 1);
        #50;
        check_state("reset", 0, 0, 3, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            tick();
            check_state($sformatf("unit%0d", i), i, i, 3, 0, 0, 0);
        end
        @(negedge clk);
        bus.VS_negedge = 1'b1;
        @(negedge clk);
        check("b2b.first", int'(bus.hpos), 4);
        @(negedge clk);
        bus.VS_negedge = 1'b0;
        check("b2b.hpos", int'(bus.hpos), 5);
        check("b2b.vpos", int'(bus.vpos), 5);

        do_reset();
        set_step(4, 1);
        for (int i = 0; i < 126; i++) tick();
        check_state("x126", 504, 126, 3, 0, 0, 0);
        tick();
        check_state("x127", 505, 127, 1, 1, 0, 0);
        @(negedge clk);
        check("x127.pulse_end", int'(bus.hit_x), 0);
        set_step(0, 1);
        tick();
        check_state("xstill", 505, 128, 1, 0, 0, 0);

        do_reset();
        bus.loc_rst = 1'b1;
        tick();
        bus.loc_rst = 1'b0;
        check_state("centre", 252, 172, 0, 0, 0, 0);
        set_step(5, 5);
        for (int i = 0; i < 34; i++) tick();
        check_state("dec34", 82, 2, 0, 0, 0, 0);
        tick();
        check_state("dec35", 77, 0, 1, 0, 1, 0);

        do_reset();
        bus.loc_rst = 1'b1;
        tick();
        bus.loc_rst = 1'b0;
        set_step(252, 172);
        tick();
        check_state("corner", 0, 0, 3, 1, 1, 1);
        @(negedge clk);
        check_state("corner.end", 0, 0, 3, 0, 0, 0);

        bus.en = 1'b0;
        set_step(5, 5);
        for (int i = 0; i < 10; i++) tick();
        check_state("frozen", 0, 0, 3, 0, 0, 0);
        bus.loc_rst = 1'b1;
        tick();
        bus.loc_rst = 1'b0;
        bus.en = 1'b1;
        check_state("frozen.centre", 252, 172, 0, 0, 0, 0);

        do_reset();
        set_step(3, 2);
        tick();
        tick();
        check_state("pre_async", 6, 4, 3, 0, 0, 0);
        @(posedge clk);
        #7 rst_n = 1'b0;
        #1 check_state("async", 0, 0, 3, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_state("async.held", 0, 0, 3, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        check_state("async.after", 3, 2, 3, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
